huffman_packer: RTL and testbench
=================================

Name: huffman_packer

Overview:
- Downstream of the Huffman code builder. Latches the six-entry code table (HC1..HC6, M1..M6) when code_valid is high.
- Then accepts a stream of gray symbols (1..6) and packs their variable-length codes MSB-first into 8-bit bytes.
- Bytes leave on a valid/ready handshake; a final partial byte is zero-padded and flagged last.

Parameters:
- NSYM, 6, number of symbols/table entries (symbol codes 1..NSYM).
- MAXLEN, 8, maximum code length in bits (width of HC/M).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- code_valid  in  1  code table valid (level; held high by producer).
- HC1..HC6  in  8 each  code value, right-aligned, valid bits given by M.
- M1..M6  in  8 each  mask of valid code bits (2^L-1, L = code length).
- sym_valid  in  1  input symbol valid.
- sym_data  in  3  symbol value 1..6.
- sym_last  in  1  marks final symbol of the stream.
- sym_ready  out  1  packer can accept a symbol this cycle.
- out_valid  out  1  packed byte valid.
- out_data  out  8  packed byte, first code bit in bit 7.
- out_last  out  1  final byte of stream (with out_valid).
- out_ready  in  1  downstream accepts byte.
- err  out  1  sticky error: bad table mask or out-of-range symbol.

Behaviour:
- Reset (reset low, async):
  - state=IDLE; bit buffer and bit count cleared.
  - sym_ready, out_valid, out_data, out_last and err all 0.
- IDLE:
  - When code_valid=1, capture all six HC/M in one cycle and go to RUN.
  - Per entry, L = popcount(M). If M != 2^L-1 or L=0, set err; that entry is then treated as L=0 (emits nothing).
- RUN:
  - sym_ready = (cnt <= 8) and not draining the last byte.
  - A symbol is accepted on sym_valid & sym_ready.
  - Accept appends the low L bits of HC[sym], MSB first, at buffer position cnt; cnt += L.
  - sym_data of 0 or 7 sets err; the symbol is dropped, but sym_last is still honoured.
- Bit buffer: 16 bits, valid bits left-aligned in [15:16-cnt]; cnt range 0..16.
- Byte output:
  - out_valid = (cnt >= 8) in RUN, with out_data = buffer[15:8].
  - On out_valid & out_ready the buffer shifts left by 8 and cnt -= 8.
- Same-cycle accept and emit: the shift and the append both apply. The append lands at position cnt-8.
- Latency: a byte completed by an accepted symbol is presented on out_valid the next cycle.
- Backpressure:
  - out_valid, out_data and out_last hold stable until out_ready.
  - sym_ready drops when cnt > 8.
- sym_last accepted: go to FLUSH; sym_ready=0 from the next cycle.
- FLUSH:
  - Emit full bytes while cnt >= 8.
  - When 0 < cnt < 8, emit buffer[15:8] with the low (8-cnt) bits zero and out_last=1.
  - If cnt reaches exactly 0 after a full byte, that byte carries out_last=1.
  - If the stream produced no bits, emit a single 0x00 with out_last=1.
  - After the last handshake go to IDLE, cnt=0. The table is recaptured on the next code_valid.
  - err holds until reset.
- code_valid dropping mid-RUN: ignored; the latched table is used.

Optional Feature:
- Macro: HUFFMAN_PACKER_BITCNT_EN.
- Defined:
  - Adds output total_bits [15:0]: count of code bits accepted since leaving IDLE, excluding pad bits.
  - Saturates at 0xFFFF, is reset to 0 on IDLE->RUN, and holds its value in IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package huffman_pkg:
  - NSYM and MAXLEN.
  - State encoding IDLE/RUN/FLUSH.
  - Symbol index type (3 bits) and code-length type (4 bits).
- One sub-module: huffman_code_len. Combinational mask-to-length (popcount plus a 2^L-1 validity check), instantiated six times.

Test Plan:
- Code table used by all scenarios:
  - sym1 = "1" (HC=01, M=01)
  - sym2 = "01" (HC=01, M=03)
  - sym3 = "000" (HC=00, M=07)
  - sym4 = "0011" (HC=03, M=0F)
  - sym5 = "00100" (HC=04, M=1F)
  - sym6 = "00101" (HC=05, M=1F)
- Scenarios:
  1. Symbols 1,1,2,3 (last on 3), out_ready=1 -> one byte 0xD0 with out_last=1; err=0.
  2. Eight sym1, last on 8th -> single byte 0xFF with out_last=1; BITCNT build: total_bits=8.
  3. Symbols 4,5 (last on 5) -> 0x32 (out_last=0), then 0x00 (out_last=1).
  4. out_ready=0 for 10 cycles during a stream of sym6 -> out_valid/out_data held stable, sym_ready drops once cnt > 8, no bits lost. After release, bytes match the golden model.
  5. sym_data=7 mid-stream -> err=1 sticky, symbol dropped, subsequent bytes equal the golden model that skips it. Separately, M3=0x05 in the table -> err=1 at capture.
  6. Assert reset mid-FLUSH -> out_valid=0, sym_ready=0 immediately. A new code_valid restarts cleanly and scenario 1 reproduces 0xD0.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman packer: table geometry, FSM states and field types.
package huffman_pkg;
  localparam int NSYM   = 6;
  localparam int MAXLEN = 8;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  typedef logic [2:0] sym_t;
  typedef logic [3:0] len_t;
endpackage

// File: rtl/huffman_code_len.sv
// Mask-to-length decode: popcount of the mask, flagged ok only for a non-empty 2^L-1 mask.
module huffman_code_len
  import huffman_pkg::*;
(
  input  logic [MAXLEN-1:0] mask,
  output len_t              len,
  output logic              ok
);
  localparam logic [MAXLEN:0] ONE = 1;

  logic [MAXLEN:0] full;

  always_comb begin
    len = '0;
    for (int i = 0; i < MAXLEN; i++) len = len + len_t'(mask[i]);
    full = (ONE << len) - ONE;
    ok   = (len != '0) && (full == {1'b0, mask});
  end
endmodule

// File: rtl/huffman_packer.sv
// Latches a six-entry Huffman code table and packs symbol codes MSB-first into bytes.
// Optional feature macro HUFFMAN_PACKER_BITCNT_EN adds a saturating total_bits output.
module huffman_packer
  import huffman_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [7:0]  HC1,
  input  logic [7:0]  HC2,
  input  logic [7:0]  HC3,
  input  logic [7:0]  HC4,
  input  logic [7:0]  HC5,
  input  logic [7:0]  HC6,
  input  logic [7:0]  M1,
  input  logic [7:0]  M2,
  input  logic [7:0]  M3,
  input  logic [7:0]  M4,
  input  logic [7:0]  M5,
  input  logic [7:0]  M6,
  input  logic        sym_valid,
  input  logic [2:0]  sym_data,
  input  logic        sym_last,
  output logic        sym_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
`ifdef HUFFMAN_PACKER_BITCNT_EN
  output logic [15:0] total_bits,
`endif
  output logic        err
);
  state_t              state;
  logic [15:0]         bit_buf;
  logic [4:0]          cnt;
  logic [MAXLEN-1:0]   code_tab [NSYM];
  len_t                len_tab  [NSYM];

  logic [MAXLEN-1:0]   hc_in [NSYM];
  logic [MAXLEN-1:0]   m_in  [NSYM];
  len_t                len_in [NSYM];
  logic [NSYM-1:0]     ok_in;

  logic                accept, emit, sym_bad;
  len_t                sel_len;
  logic [MAXLEN-1:0]   sel_code;
  logic [15:0]         base_buf, next_buf;
  logic [4:0]          base_cnt, next_cnt;

  assign hc_in[0] = HC1;  assign m_in[0] = M1;
  assign hc_in[1] = HC2;  assign m_in[1] = M2;
  assign hc_in[2] = HC3;  assign m_in[2] = M3;
  assign hc_in[3] = HC4;  assign m_in[3] = M4;
  assign hc_in[4] = HC5;  assign m_in[4] = M5;
  assign hc_in[5] = HC6;  assign m_in[5] = M6;

  for (genvar i = 0; i < NSYM; i++) begin : g_len
    huffman_code_len u_len (
      .mask (m_in[i]),
      .len  (len_in[i]),
      .ok   (ok_in[i])
    );
  end

  assign sym_ready = (state == RUN) && (cnt <= 5'd8);
  assign out_valid = ((state == RUN) && (cnt >= 5'd8)) || (state == FLUSH);
  assign out_last  = (state == FLUSH) && (cnt <= 5'd8);
  assign out_data  = bit_buf[15:8];
  assign accept    = sym_valid & sym_ready;
  assign emit      = out_valid & out_ready;

  // A simultaneous emit shifts first, so the appended code lands at cnt-8.
  always_comb begin
    sel_len  = '0;
    sel_code = '0;
    sym_bad  = 1'b0;
    if (accept) begin
      if (sym_data >= sym_t'(1) && sym_data <= sym_t'(NSYM)) begin
        sel_len  = len_tab[sym_data - sym_t'(1)];
        sel_code = code_tab[sym_data - sym_t'(1)];
      end else begin
        sym_bad = 1'b1;
      end
    end
    base_buf = emit ? {bit_buf[7:0], 8'h00} : bit_buf;
    base_cnt = emit ? (cnt - 5'd8) : cnt;
    next_buf = base_buf | ({8'h00, sel_code} << (5'd16 - base_cnt - {1'b0, sel_len}));
    next_cnt = base_cnt + {1'b0, sel_len};
  end

  // Table storage carries no reset; it is only meaningful after a capture.
  always_ff @(posedge clk) begin
    if (state == IDLE && code_valid) begin
      for (int i = 0; i < NSYM; i++) begin
        code_tab[i] <= ok_in[i] ? (hc_in[i] & m_in[i]) : '0;
        len_tab[i]  <= ok_in[i] ? len_in[i] : '0;
      end
    end
  end

`ifdef HUFFMAN_PACKER_BITCNT_EN
  logic [16:0] bits_sum;
  assign bits_sum = {1'b0, total_bits} + {13'b0, sel_len};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_buf <= '0;
      cnt     <= '0;
      err     <= 1'b0;
`ifdef HUFFMAN_PACKER_BITCNT_EN
      total_bits <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (code_valid) begin
            state   <= RUN;
            bit_buf <= '0;
            cnt     <= '0;
            if (!(&ok_in)) err <= 1'b1;
`ifdef HUFFMAN_PACKER_BITCNT_EN
            total_bits <= '0;
`endif
          end
        end
        RUN: begin
          bit_buf <= next_buf;
          cnt     <= next_cnt;
          if (sym_bad) err <= 1'b1;
          if (accept && sym_last) state <= FLUSH;
`ifdef HUFFMAN_PACKER_BITCNT_EN
          total_bits <= bits_sum[16] ? 16'hFFFF : bits_sum[15:0];
`endif
        end
        FLUSH: begin
          if (out_ready) begin
            if (cnt <= 5'd8) begin
              state   <= IDLE;
              bit_buf <= '0;
              cnt     <= '0;
            end else begin
              bit_buf <= next_buf;
              cnt     <= next_cnt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_huffman_packer.sv
// Directed bench for huffman_packer: a bit-level reference model fills a scoreboard of bytes.
module tb_huffman_packer;
  logic        clk = 1'b0;
  logic        reset;
  logic        code_valid;
  logic [7:0]  HC1, HC2, HC3, HC4, HC5, HC6;
  logic [7:0]  M1, M2, M3, M4, M5, M6;
  logic        sym_valid;
  logic [2:0]  sym_data;
  logic        sym_last;
  logic        sym_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        err;
`ifdef HUFFMAN_PACKER_BITCNT_EN
  logic [15:0] total_bits;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [8:0]  exp_q[$];
  int          stim_q[$];
  int          exp_len [1:6];
  logic [7:0]  exp_code [1:6];

  huffman_packer dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .HC1 (HC1), .HC2 (HC2), .HC3 (HC3), .HC4 (HC4), .HC5 (HC5), .HC6 (HC6),
    .M1  (M1),  .M2  (M2),  .M3  (M3),  .M4  (M4),  .M5  (M5),  .M6  (M6),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .sym_last   (sym_last),
    .sym_ready  (sym_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
`ifdef HUFFMAN_PACKER_BITCNT_EN
    .total_bits (total_bits),
`endif
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: concatenate code bits, cut into bytes, zero-pad the tail, flag the final byte.
  task automatic model_push();
    bit bq[$];
    logic [7:0] by;
    foreach (stim_q[i]) begin
      int s;
      s = stim_q[i];
      if (s >= 1 && s <= 6)
        for (int b = exp_len[s] - 1; b >= 0; b--) bq.push_back(exp_code[s][b]);
    end
    if (bq.size() == 0) exp_q.push_back(9'h100);
    while (bq.size() > 0) begin
      by = 8'h00;
      for (int k = 7; k >= 0; k--) if (bq.size() > 0) by[k] = bq.pop_front();
      exp_q.push_back({(bq.size() == 0), by});
    end
  endtask

  task automatic drive_from(input int start);
    for (int i = start; i < stim_q.size(); i++) begin
      int waitc;
      waitc     = 0;
      sym_valid = 1'b1;
      sym_data  = 3'(stim_q[i]);
      sym_last  = (i == stim_q.size() - 1);
      @(negedge clk);
      while (!sym_ready && waitc < 100) begin
        @(negedge clk);
        waitc++;
      end
      if (waitc >= 100) check("sym_ready_wait", 32'(sym_ready), 32'd1);
      @(posedge clk); #1;
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    sym_data  = 3'd0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_byte", 32'(out_valid), 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("byte", 32'({out_last, out_data}), 32'(e));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int acc, changes;
    logic [7:0] held;
    bit seen;

    exp_code[1] = 8'h01; exp_len[1] = 1;
    exp_code[2] = 8'h01; exp_len[2] = 2;
    exp_code[3] = 8'h00; exp_len[3] = 3;
    exp_code[4] = 8'h03; exp_len[4] = 4;
    exp_code[5] = 8'h04; exp_len[5] = 5;
    exp_code[6] = 8'h05; exp_len[6] = 5;
    HC1 = 8'h01; M1 = 8'h01;
    HC2 = 8'h01; M2 = 8'h03;
    HC3 = 8'h00; M3 = 8'h07;
    HC4 = 8'h03; M4 = 8'h0F;
    HC5 = 8'h04; M5 = 8'h1F;
    HC6 = 8'h05; M6 = 8'h1F;
    reset = 1'b0; code_valid = 1'b0;
    sym_valid = 1'b0; sym_data = 3'd0; sym_last = 1'b0; out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sym_ready", 32'(sym_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_err",       32'(err),       32'd0);

    code_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("run_sym_ready", 32'(sym_ready), 32'd1);

    // Scenario 1: 1,1,2,3 -> 0xD0 last
    stim_q = '{1, 1, 2, 3};
    exp_q.push_back(9'h1D0);
    drive_from(0);
    wait_drain("s1_drain");
    check("s1_err", 32'(err), 32'd0);

    // Scenario 2: eight sym1 -> 0xFF last
    stim_q = '{1, 1, 1, 1, 1, 1, 1, 1};
    exp_q.push_back(9'h1FF);
    drive_from(0);
`ifdef HUFFMAN_PACKER_BITCNT_EN
    check("s2_total_bits", 32'(total_bits), 32'd8);
`endif
    wait_drain("s2_drain");

    // Scenario 3: 4,5 -> 0x32 then 0x00 last
    stim_q = '{4, 5};
    exp_q.push_back(9'h032);
    exp_q.push_back(9'h100);
    drive_from(0);
    wait_drain("s3_drain");

    // Scenario 4: sym6 stream held off by out_ready=0 for 10 cycles
    stim_q = '{6, 6, 6, 6, 6, 6};
    model_push();
    out_ready = 1'b0;
    acc = 0; changes = 0; seen = 1'b0; held = 8'h00;
    sym_valid = 1'b1; sym_data = 3'd6; sym_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (sym_ready) acc++;
      if (out_valid) begin
        if (seen && out_data != held) changes++;
        held = out_data;
        seen = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("s4_accepted",   32'(acc),       32'd2);
    check("s4_sym_ready",  32'(sym_ready), 32'd0);
    check("s4_out_valid",  32'(out_valid), 32'd1);
    check("s4_held_data",  32'(out_data),  32'(exp_q[0][7:0]));
    check("s4_stable",     32'(changes),   32'd0);
    out_ready = 1'b1;
    drive_from(acc);
    wait_drain("s4_drain");

    // Scenario 5a: illegal symbol 7 mid-stream is dropped and flags err
    stim_q = '{2, 4, 7, 1, 6, 3};
    model_push();
    drive_from(0);
    check("s5_err_sym", 32'(err), 32'd1);
    wait_drain("s5_drain");
    check("s5_err_sticky", 32'(err), 32'd1);

    // Scenario 5b: M3=0x05 is a malformed mask; entry 3 then emits nothing
    reset = 1'b0;
    M3 = 8'h05;
    @(posedge clk); #1;
    check("s5b_err_cleared", 32'(err), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("s5b_err_table", 32'(err), 32'd1);
    exp_len[3] = 0;
    stim_q = '{3, 1};
    model_push();
    drive_from(0);
    wait_drain("s5b_drain");

    // Scenario 6: reset while FLUSH is holding a byte, then clean restart
    reset = 1'b0;
    M3 = 8'h07;
    exp_len[3] = 3;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("s6_err_clean", 32'(err), 32'd0);
    out_ready = 1'b0;
    stim_q = '{1, 1, 2, 3};
    drive_from(0);
    check("s6_flush_valid", 32'(out_valid), 32'd1);
    check("s6_flush_last",  32'(out_last),  32'd1);
    check("s6_flush_data",  32'(out_data),  32'hD0);
    reset = 1'b0;
    #1;
    check("s6_rst_out_valid", 32'(out_valid), 32'd0);
    check("s6_rst_sym_ready", 32'(sym_ready), 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.push_back(9'h1D0);
    drive_from(0);
    wait_drain("s6_drain");
    check("s6_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
